barrett_reduce_pipe: RTL

//  Pipelined Barrett modular reducer directly downstream of the oka multiplier in the NTT butterfly datapath.

---
 rtl/ntt_params_pkg.sv | 7 +
 rtl/mod_csub.sv | 14 +
 rtl/barrett_reduce_pipe.sv | 84 ++++++++
 3 files changed

// File: rtl/ntt_params_pkg.sv
// Shared NTT datapath constants, consumed by the oka multiplier and the Barrett reducer.
package ntt_params_pkg;
  localparam int unsigned         NTT_WI = 32;
  localparam int unsigned         NTT_WT = 8;
  localparam logic [NTT_WI-1:0]   NTT_Q  = 32'hC000_0001;
  localparam logic [NTT_WI:0]     NTT_MU = 33'd5726623059;
endpackage

// File: rtl/mod_csub.sv
// Conditional modular subtract: r >= Q ? r - Q : r, result truncated to WO bits.
module mod_csub #(
  parameter int unsigned W  = 34,
  parameter int unsigned WO = 34,
  parameter logic [W-1:0] Q = '0
) (
  input  logic [W-1:0]  r_i,
  output logic [WO-1:0] r_o
);
  always_comb begin
    if (r_i >= Q) r_o = WO'(r_i - Q);
    else          r_o = WO'(r_i);
  end
endmodule

// File: rtl/barrett_reduce_pipe.sv
// Three-stage Barrett reducer: iProd mod Q with a valid/ready handshake and a tag sideband.
module barrett_reduce_pipe
  import ntt_params_pkg::*;
#(
  parameter int unsigned  wI = NTT_WI,
  parameter int unsigned  wO = 2*NTT_WI,
  parameter logic [wI-1:0] Q  = NTT_Q,
  parameter logic [wI:0]   MU = NTT_MU,
  parameter int unsigned  wT = NTT_WT
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iValid,
  output logic          oReady,
  input  logic [wO-1:0] iProd,
  input  logic [wT-1:0] iTag,
  output logic          oValid,
  input  logic          iReady,
  output logic [wI-1:0] oRes,
  output logic [wT-1:0] oTag
);
  logic ld1, ld2, ld3;
  logic v1_q, v2_q, v3_q;

  // Only q2 >> (wI+1) and the low wI+2 product bits are ever consumed, so only those are kept.
  logic [wI:0]   q3_d,    q3_q;
  logic [wI+1:0] prod1_d, prod1_q;
  logic [wT-1:0] tag1_q;
  logic [wI+1:0] r2_d,    r2_q;
  logic [wT-1:0] tag2_q;
  logic [wI+1:0] c1;
  logic [wI-1:0] res3_d,  res3_q;
  logic [wT-1:0] tag3_q;

  assign ld3    = !v3_q | iReady;
  assign ld2    = !v2_q | ld3;
  assign ld1    = !v1_q | ld2;
  assign oReady = ld1;

  always_comb begin
    q3_d    = (wI+1)'(((wO+2)'(iProd >> (wI-1)) * (wO+2)'(MU)) >> (wI+1));
    prod1_d = iProd[wI+1:0];
    r2_d    = prod1_q - ((wI+2)'(q3_q) * (wI+2)'(Q));
  end

  mod_csub #(.W(wI+2), .WO(wI+2), .Q({2'b00, Q})) u_csub0 (.r_i(r2_q), .r_o(c1));
  mod_csub #(.W(wI+2), .WO(wI),   .Q({2'b00, Q})) u_csub1 (.r_i(c1),   .r_o(res3_d));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      q3_q    <= '0;
      prod1_q <= '0;
      tag1_q  <= '0;
      r2_q    <= '0;
      tag2_q  <= '0;
      res3_q  <= '0;
      tag3_q  <= '0;
    end else begin
      if (ld1) v1_q <= iValid;
      if (ld2) v2_q <= v1_q;
      if (ld3) v3_q <= v2_q;
      if (ld1 && iValid) begin
        q3_q    <= q3_d;
        prod1_q <= prod1_d;
        tag1_q  <= iTag;
      end
      if (ld2 && v1_q) begin
        r2_q   <= r2_d;
        tag2_q <= tag1_q;
      end
      if (ld3 && v2_q) begin
        res3_q <= res3_d;
        tag3_q <= tag2_q;
      end
    end
  end

  assign oValid = v3_q;
  assign oRes   = res3_q;
  assign oTag   = tag3_q;
endmodule
